// File: rtl/food_spawner.sv
// food_spawner: turns the free-running random cell stream into a food position
// that lies inside the playfield walls and does not overlap the snake body.
// The snake body is scanned through a synchronous-read segment RAM port.
module food_spawner #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int WALL_WIDTH = 10,
    parameter int ADDR_W     = 5,
    parameter int MAX_LEN    = 32,
    parameter int MAX_TRIES  = 16
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic [10:0]       rand_x,
    input  logic [10:0]       rand_y,
    input  logic [10:0]       cell_size,
    input  logic              spawn_req,
    input  logic [ADDR_W:0]   snake_len,
    output logic [ADDR_W-1:0] seg_addr,
    input  logic [10:0]       seg_x,
    input  logic [10:0]       seg_y,
    output logic [10:0]       food_x,
    output logic [10:0]       food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              spawn_fail
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    // Playfield limits at 12 bits so candidate + cell_size never wraps.
    localparam logic [11:0]       WALL_LO = 12'(WALL_WIDTH);
    localparam logic [11:0]       X_HI    = 12'(WIDTH - WALL_WIDTH);
    localparam logic [11:0]       Y_HI    = 12'(HEIGHT - WALL_WIDTH);
    localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [TRY_W-1:0]  TRY_MAX = TRY_W'(MAX_TRIES);

    typedef enum logic [1:0] {IDLE, SAMPLE, BOUND, SCAN} state_t;

    state_t            state_q;
    logic [10:0]       cand_x_q, cand_y_q, cell_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt_q;
    logic [TRY_W-1:0]  try_q;
    logic [ADDR_W-1:0] seg_addr_q;
    logic [10:0]       food_x_q, food_y_q;
    logic              food_valid_q, busy_q, spawn_fail_q;

    logic [ADDR_W:0]   len_d;
    logic [TRY_W-1:0]  try_d;
    logic [ADDR_W:0]   next_addr;
    logic [11:0]       sum_x, sum_y;
    logic              bound_ok, hit, scan_done, retry;

    assign len_d     = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
    assign try_d     = try_q + 1'b1;
    assign next_addr = cnt_q + 1'b1;
    assign sum_x     = {1'b0, cand_x_q} + {1'b0, cell_q};
    assign sum_y     = {1'b0, cand_y_q} + {1'b0, cell_q};
    assign bound_ok  = ({1'b0, cand_x_q} >= WALL_LO) && ({1'b0, cand_y_q} >= WALL_LO) &&
                       (sum_x <= X_HI) && (sum_y <= Y_HI);
    // cnt_q counts SCAN cycles; from cnt_q = 1 on, the RAM returns address cnt_q-1.
    assign hit       = (cnt_q != '0) && (seg_x == cand_x_q) && (seg_y == cand_y_q);
    assign scan_done = (cnt_q == len_q);
    assign retry     = ((state_q == BOUND) && !bound_ok) || ((state_q == SCAN) && hit);

    // Request sequencing: sample, wall check, body scan, then commit/retry/fail.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cand_x_q      <= '0;
            cand_y_q      <= '0;
            cell_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            try_q         <= '0;
            seg_addr_q    <= '0;
            food_x_q      <= '0;
            food_y_q      <= '0;
            food_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            spawn_fail_q  <= 1'b0;
        end else begin
            spawn_fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (spawn_req) begin
                        state_q      <= SAMPLE;
                        busy_q       <= 1'b1;
                        food_valid_q <= 1'b0;
                        try_q        <= '0;
                        cell_q       <= cell_size;
                        len_q        <= len_d;
                    end
                end
                SAMPLE: begin
                    cand_x_q <= rand_x;
                    cand_y_q <= rand_y;
                    state_q  <= BOUND;
                end
                BOUND: begin
                    if (bound_ok) begin
                        state_q    <= SCAN;
                        seg_addr_q <= '0;
                        cnt_q      <= '0;
                    end
                end
                SCAN: begin
                    if (!hit) begin
                        if (scan_done) begin
                            food_x_q     <= cand_x_q;
                            food_y_q     <= cand_y_q;
                            food_valid_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            cnt_q <= next_addr;
                            // Past the last segment the address just holds for the drain cycle.
                            if (next_addr < len_q) begin
                                seg_addr_q <= next_addr[ADDR_W-1:0];
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A rejected candidate either starts a fresh attempt or ends the request.
            if (retry) begin
                try_q <= try_d;
                if (try_d == TRY_MAX) begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    spawn_fail_q <= 1'b1;
                end else begin
                    state_q <= SAMPLE;
                end
            end
        end
    end

    assign seg_addr   = seg_addr_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = busy_q;
    assign spawn_fail = spawn_fail_q;

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner: a segment RAM model plus a timeline model of the
// request (attempt start cycles, wall test, first colliding segment).
module tb_food_spawner;

    localparam int MAX_LEN   = 32;
    localparam int MAX_TRIES = 16;
    localparam int TAB       = 1024;

    logic        vga_clk;
    logic        rst_n;
    logic [10:0] rand_x, rand_y, cell_size;
    logic        spawn_req;
    logic [5:0]  snake_len;
    logic [4:0]  seg_addr;
    logic [10:0] seg_x, seg_y;
    logic [10:0] food_x, food_y;
    logic        food_valid, busy, spawn_fail;

    logic [10:0] seg_xm [32];
    logic [10:0] seg_ym [32];
    logic [10:0] rx_tab [TAB];
    logic [10:0] ry_tab [TAB];

    int          errors;
    int          checks;
    string       tname;
    logic [10:0] cur_fx, cur_fy;

    food_spawner dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .rand_x     (rand_x),
        .rand_y     (rand_y),
        .cell_size  (cell_size),
        .spawn_req  (spawn_req),
        .snake_len  (snake_len),
        .seg_addr   (seg_addr),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .spawn_fail (spawn_fail)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Synchronous-read snake segment RAM
    always @(posedge vga_clk) begin
        seg_x <= seg_xm[seg_addr];
        seg_y <= seg_ym[seg_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0d expected=%0d", tname, tag, obs, exp);
        end
    endtask

    // Timeline model: attempt k samples the random stream in cycle s (cycle 0 = request).
    // Wall reject -> next attempt at s+2; hit on segment h -> s+4+h;
    // clean scan of n segments -> food visible at s+3+n.
    task automatic model(output int e, output bit ok, output logic [10:0] fx, output logic [10:0] fy);
        int s, n, tries, cx, cy, cs, hit, nxt;
        bit inb;
        n     = (int'(snake_len) > MAX_LEN) ? MAX_LEN : int'(snake_len);
        cs    = int'(cell_size);
        s     = 1;
        tries = 0;
        ok    = 1'b0;
        fx    = '0;
        fy    = '0;
        e     = 0;
        while (1) begin
            cx  = int'(rx_tab[s]);
            cy  = int'(ry_tab[s]);
            inb = (cx >= 10) && (cy >= 10) && (cx + cs <= 1270) && (cy + cs <= 710);
            if (inb) begin
                hit = -1;
                for (int k = 0; k < n; k++) begin
                    if (hit < 0 && int'(seg_xm[k]) == cx && int'(seg_ym[k]) == cy) hit = k;
                end
                if (hit < 0) begin
                    e  = s + 3 + n;
                    ok = 1'b1;
                    fx = 11'(cx);
                    fy = 11'(cy);
                    return;
                end
                nxt = s + 4 + hit;
            end else begin
                nxt = s + 2;
            end
            tries++;
            if (tries == MAX_TRIES) begin
                e = nxt;
                return;
            end
            s = nxt;
        end
    endtask

    // Issue one request (optionally a second pulse while busy) and check every cycle.
    task automatic run_request(input bit dbl_req);
        int e;
        bit ok;
        logic [10:0] fx, fy;
        model(e, ok, fx, fy);
        for (int c = 0; c <= e + 3; c++) begin
            @(posedge vga_clk);
            #1;
            spawn_req = (c == 0) || (dbl_req && c == 3);
            rand_x    = rx_tab[c];
            rand_y    = ry_tab[c];
            @(negedge vga_clk);
            if (c >= 1) begin
                chk("busy",       32'(busy),       32'(c < e));
                chk("food_valid", 32'(food_valid), 32'(ok && c >= e));
                chk("spawn_fail", 32'(spawn_fail), 32'(!ok && c == e));
                chk("food_x",     32'(food_x),     32'((ok && c >= e) ? fx : cur_fx));
                chk("food_y",     32'(food_y),     32'((ok && c >= e) ? fy : cur_fy));
            end
        end
        spawn_req = 1'b0;
        if (ok) begin
            cur_fx = fx;
            cur_fy = fy;
        end
    endtask

    task automatic fill_const(input int x, input int y);
        for (int c = 0; c < TAB; c++) begin
            rx_tab[c] = 11'(x);
            ry_tab[c] = 11'(y);
        end
    endtask

    task automatic fill_random();
        int sel, k, cs;
        cs = int'(cell_size);
        for (int i = 0; i < 32; i++) begin
            seg_xm[i] = 11'($urandom_range(10, 1250));
            seg_ym[i] = 11'($urandom_range(10, 690));
        end
        for (int c = 0; c < TAB; c++) begin
            sel = int'($urandom_range(0, 6));
            rx_tab[c] = 11'($urandom_range(10, 1270 - cs));
            ry_tab[c] = 11'($urandom_range(10, 710 - cs));
            case (sel)
                0, 1: begin
                    k = int'($urandom_range(0, 31));
                    rx_tab[c] = seg_xm[k];
                    ry_tab[c] = seg_ym[k];
                end
                2: rx_tab[c] = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 9))
                                                           : 11'($urandom_range(1261, 2047));
                3: ry_tab[c] = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 9))
                                                           : 11'($urandom_range(701, 2047));
                4: begin
                    rx_tab[c] = 11'(1270 - cs + int'($urandom_range(0, 1)));
                    ry_tab[c] = 11'(710 - cs + int'($urandom_range(0, 1)));
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        int sizes [4];
        sizes = '{8, 10, 16, 20};
        errors    = 0;
        checks    = 0;
        cur_fx    = '0;
        cur_fy    = '0;
        rst_n     = 1'b0;
        spawn_req = 1'b0;
        rand_x    = '0;
        rand_y    = '0;
        cell_size = 11'd10;
        snake_len = '0;
        for (int i = 0; i < 32; i++) begin
            seg_xm[i] = 11'd600;
            seg_ym[i] = 11'd600;
        end
        fill_const(0, 0);

        // Reset state
        tname = "reset";
        repeat (3) @(posedge vga_clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge vga_clk);
        chk("food_valid", 32'(food_valid), 32'(0));
        chk("busy",       32'(busy),       32'(0));
        chk("spawn_fail", 32'(spawn_fail), 32'(0));
        chk("food_x",     32'(food_x),     32'(0));
        chk("food_y",     32'(food_y),     32'(0));
        chk("seg_addr",   32'(seg_addr),   32'(0));

        // Empty snake, minimum legal corner
        tname = "len0";
        snake_len = 6'd0;
        cell_size = 11'd10;
        fill_const(10, 10);
        run_request(1'b0);

        // Collision on segment 1, second candidate commits
        tname = "collide";
        snake_len = 6'd3;
        seg_xm[0] = 11'd10; seg_ym[0] = 11'd10;
        seg_xm[1] = 11'd20; seg_ym[1] = 11'd10;
        seg_xm[2] = 11'd30; seg_ym[2] = 11'd10;
        fill_const(50, 40);
        rx_tab[0] = 11'd20; ry_tab[0] = 11'd10;
        rx_tab[1] = 11'd20; ry_tab[1] = 11'd10;
        run_request(1'b0);

        // Wall reject then exact right/bottom limit
        tname = "walls";
        snake_len = 6'd0;
        fill_const(1260, 700);
        rx_tab[0] = 11'd1275; ry_tab[0] = 11'd30;
        rx_tab[1] = 11'd1275; ry_tab[1] = 11'd30;
        run_request(1'b0);

        // Every candidate collides -> MAX_TRIES exhausted
        tname = "exhaust";
        snake_len = 6'd1;
        seg_xm[0] = 11'd100; seg_ym[0] = 11'd100;
        fill_const(100, 100);
        run_request(1'b0);

        // Second request while busy is ignored
        tname = "dblreq";
        snake_len = 6'd3;
        seg_xm[0] = 11'd40; seg_xm[1] = 11'd50; seg_xm[2] = 11'd60;
        fill_const(300, 300);
        run_request(1'b1);

        // Reset in the middle of a scan
        tname = "midreset";
        snake_len = 6'd10;
        for (int i = 0; i < 32; i++) begin
            seg_xm[i] = 11'd500;
            seg_ym[i] = 11'd500;
        end
        fill_const(200, 200);
        @(posedge vga_clk);
        #1 spawn_req = 1'b1;
        rand_x = 11'd200;
        rand_y = 11'd200;
        @(posedge vga_clk);
        #1 spawn_req = 1'b0;
        repeat (5) @(posedge vga_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("busy",       32'(busy),       32'(0));
        chk("food_valid", 32'(food_valid), 32'(0));
        chk("spawn_fail", 32'(spawn_fail), 32'(0));
        chk("food_x",     32'(food_x),     32'(0));
        chk("food_y",     32'(food_y),     32'(0));
        chk("seg_addr",   32'(seg_addr),   32'(0));
        repeat (2) @(posedge vga_clk);
        #1 rst_n = 1'b1;
        cur_fx = '0;
        cur_fy = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge vga_clk);
            chk("after_busy", 32'(busy),       32'(0));
            chk("after_fail", 32'(spawn_fail), 32'(0));
            chk("after_fv",   32'(food_valid), 32'(0));
        end

        // Randomized requests
        tname = "random";
        for (int r = 0; r < 30; r++) begin
            snake_len = 6'($urandom_range(0, 40));
            cell_size = 11'(sizes[$urandom_range(0, 3)]);
            fill_random();
            run_request(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/food_spawner.md
Name: food_spawner

Overview:
- Consumes the free-running `rand_x`/`rand_y` cell-position stream from the random position generator.
- Turns it into a validated food position on request:
  - rejects candidates outside the playfield walls;
  - rejects candidates that overlap any snake segment, by scanning the snake body memory through a synchronous read port.
- Sits between the game controller (issues `spawn_req`, consumes `food_x`/`food_y`/`food_valid`) and the snake segment RAM.

Parameters:
- WIDTH, 1280, screen width in pixels
- HEIGHT, 720, screen height in pixels
- WALL_WIDTH, 10, wall thickness in pixels
- ADDR_W, 5, snake segment RAM address width
- MAX_LEN, 32, maximum snake length; must be <= 2**ADDR_W
- MAX_TRIES, 16, candidate attempts per request before failure

Ports:
- vga_clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- rand_x  in  11  candidate X from random position generator
- rand_y  in  11  candidate Y from random position generator
- cell_size  in  11  cell edge in pixels
- spawn_req  in  1  one-cycle request for a new food position
- snake_len  in  ADDR_W+1  current number of valid segments
- seg_addr  out  ADDR_W  segment RAM read address
- seg_x  in  11  segment X; valid one cycle after seg_addr
- seg_y  in  11  segment Y; valid one cycle after seg_addr
- food_x  out  11  committed food X
- food_y  out  11  committed food Y
- food_valid  out  1  high while food_x/food_y hold a committed position
- busy  out  1  high from request acceptance until commit or fail
- spawn_fail  out  1  one-cycle pulse when MAX_TRIES is exhausted

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; food_x = food_y = 0; food_valid = 0; busy = 0; spawn_fail = 0; seg_addr = 0; try count = 0.
  - Reset mid-operation abandons the request; no commit, no fail pulse.
- State machine: IDLE, SAMPLE, BOUND, SCAN.
- IDLE:
  - spawn_req = 1 at cycle t moves to SAMPLE at t+1.
  - Same edge: busy <= 1, food_valid <= 0, try count <= 0.
  - Same edge: latch cell_size, and snake_len clamped to MAX_LEN (value N).
  - spawn_req while busy is ignored and has no queuing.
- SAMPLE (1 cycle): register cand_x = rand_x and cand_y = rand_y; go to BOUND.
- BOUND (1 cycle):
  - Pass condition: cand_x >= WALL_WIDTH, cand_y >= WALL_WIDTH, cand_x + cell_size <= WIDTH - WALL_WIDTH, cand_y + cell_size <= HEIGHT - WALL_WIDTH.
  - Sums are computed at 12 bits; no wrap.
  - Pass: go to SCAN with seg_addr <= 0.
  - Fail: retry.
- SCAN:
  - Issue seg_addr = 0..N-1 on consecutive cycles, then one drain cycle.
  - Compare seg_x/seg_y for address k in the cycle after address k is issued.
  - Match (seg_x == cand_x and seg_y == cand_y) aborts the scan immediately and retries.
  - No match after N compares: commit food_x = cand_x, food_y = cand_y, food_valid <= 1, busy <= 0, back to IDLE.
  - N = 0: SCAN lasts exactly one cycle, then commits.
- Retry:
  - try count + 1; if it reaches MAX_TRIES, pulse spawn_fail for 1 cycle, busy <= 0, food_valid stays 0, go to IDLE.
  - Otherwise return to SAMPLE. rand_x/rand_y have advanced, so a fresh candidate is taken.
- Latency: first-try success for length N gives food_valid = 1 from cycle t+4+N; busy deasserts on the same edge.
- food_x/food_y are stable while food_valid = 1 and change only on commit.
- seg_addr holds its last value outside SCAN.

Test Plan:
- Reset, then rst_n high, no request -> food_valid = 0, busy = 0, food_x = food_y = 0, spawn_fail = 0.
- snake_len = 0; spawn_req at t with rand = (10, 10), cell_size = 10 -> food = (10, 10), food_valid rises at t+4, busy low at t+4.
- snake_len = 3 with segments (10,10), (20,10), (30,10); rand held at (20,10) for attempt 1, then (50,40) -> attempt 1 rejected at the addr-1 compare, food = (50,40) committed, try count 1.
- rand = (1275, 30), cell_size = 10 -> BOUND rejects (1285 > 1270), retry; then rand = (1260, 700) -> committed (1270 <= 1270, 710 <= 710).
- Every candidate collides (snake_len = 1, segment equal to constant rand) -> exactly MAX_TRIES = 16 attempts, single spawn_fail pulse, food_valid = 0, busy = 0.
- spawn_req pulsed again while busy -> ignored, one commit only. rst_n low mid-SCAN -> all outputs at reset values immediately, no spawn_fail.
